// File: rtl/qbert_stream_pkg.sv
// Shared defaults, FSM state type and data word type for the memory stream reader.
package qbert_stream_pkg;

    localparam int DEF_ADDR_W    = 13;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MEM_WORDS = 5000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/qbert_stream_fifo.sv
// Synchronous prefetch FIFO; push and pop may coincide at any occupancy.
module qbert_stream_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (PW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign head_data = store[rd_ptr];

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/qbert_test2_mem_stream_reader.sv
// Avalon-MM read master streaming a contiguous word run out of on-chip memory.
// Define STREAM_CHECKSUM_EN to enable the running checksum of streamed words.
import qbert_stream_pkg::*;

module qbert_test2_mem_stream_reader #(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MEM_WORDS    = DEF_MEM_WORDS,
    parameter int FIFO_DEPTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [31:0]       checksum
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                  state;
    logic [ADDR_W-1:0]       addr;
    logic [ADDR_W-1:0]       remaining;
    logic [ADDR_W-1:0]       out_rem;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             credit_used;
    logic [READ_LATENCY-1:0] rd_vld;
    logic                    issue;
    logic                    push;
    logic                    xfer;
    logic                    last_xfer;
    logic                    fifo_full;
    logic                    fifo_empty;

    // Credits cover both buffered words and reads whose data is still returning.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign issue       = (state == FETCH) && (remaining != '0) &&
                         (credit_used < (CW+1)'(FIFO_DEPTH));
    assign push        = rd_vld[READ_LATENCY-1];
    assign out_valid   = !fifo_empty;
    assign xfer        = out_valid && out_ready;
    assign out_last    = out_valid && (out_rem == ADDR_W'(1));
    assign last_xfer   = xfer && out_last;

    assign busy           = (state == FETCH) || (state == DRAIN);
    assign done           = (state == FIN);
    assign mem_chipselect = issue;
    assign mem_address    = addr;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;

    qbert_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (mem_readdata),
        .pop       (xfer),
        .head_data (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            out_rem   <= '0;
            inflight  <= '0;
            rd_vld    <= '0;
        end else begin
            rd_vld[0] <= issue;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                rd_vld[i] <= rd_vld[i-1];
            end

            case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase

            if (xfer) begin
                out_rem <= out_rem - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= start_addr;
                        remaining <= word_count;
                        out_rem   <= word_count;
                        state     <= (word_count == '0) ? FIN : FETCH;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        remaining <= remaining - 1'b1;
                        addr      <= (addr == ADDR_W'(MEM_WORDS-1)) ? '0 : addr + 1'b1;
                        if (remaining == ADDR_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                // The final handshake implies nothing is in flight or buffered,
                // so leaving here puts done one cycle after it.
                DRAIN: begin
                    if (last_xfer) begin
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && fifo_full && !xfer));
        end
    end

`ifdef STREAM_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + 32'(out_data);
        end
    end
`else
    assign checksum = '0;
`endif

endmodule
